uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_baudrate_generator.sv | 33 +++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter slice.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int OVERSAMPLE_RATE = 16;
  localparam int DEFAULT_NB_DATA = 8;
  localparam int DEFAULT_NB_STOP = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_baudrate_generator.sv
// Oversampling tick source: one-clock o_tick pulse every
// round(CLK_FREQ / (BAUD_RATE * OVERSAMPLING)) clocks.
module baudrate_generator #(
  parameter int BAUD_RATE    = 19200,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int OVERSAMPLING = 16
) (
  input  logic clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int TICK_RATE = BAUD_RATE * OVERSAMPLING;
  localparam int DIVISOR   = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
  localparam int CNT_W     = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count  <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= (count == CNT_LAST);
      if (count == CNT_LAST) count <= '0;
      else                   count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional even
// parity bit (macro UART_TX_PARITY_EN), then NB_STOP ticks of stop level.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int NB_DATA = DEFAULT_NB_DATA,
  parameter int NB_STOP = DEFAULT_NB_STOP
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_start_tx,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_txdone,
  output logic               o_data
);

  localparam int TICK_W = $clog2((NB_STOP > OVERSAMPLE_RATE) ? NB_STOP : OVERSAMPLE_RATE);
  localparam int BIT_W  = $clog2(NB_DATA + 1);
  localparam logic [TICK_W-1:0] BIT_TICK_LAST  = TICK_W'(OVERSAMPLE_RATE - 1);
  localparam logic [TICK_W-1:0] STOP_TICK_LAST = TICK_W'(NB_STOP - 1);
  localparam logic [BIT_W-1:0]  BIT_CNT_LAST   = BIT_W'(NB_DATA - 1);

  tx_state_t          state;
  logic [NB_DATA-1:0] shreg;
  logic [NB_DATA-1:0] shreg_shifted;
  logic [TICK_W-1:0]  tick_cnt;
  logic [BIT_W-1:0]   bit_cnt;
`ifdef UART_TX_PARITY_EN
  logic               parity_bit;
`endif

  assign shreg_shifted = shreg >> 1;

  // o_data is loaded together with the state change, so the line level is
  // always a register output and matches the current state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the shift register is a plain flop bank, not a memory, so it is
      // cleared with the rest of the state on reset.
      state    <= IDLE;
      shreg    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      o_data   <= 1'b1;
      o_txdone <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      o_txdone <= 1'b0;
      unique case (state)
        IDLE: begin
          o_data <= 1'b1;
          if (i_start_tx) begin
            shreg    <= i_data;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
            o_data   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^i_data;
`endif
          end
        end
        START: begin
          if (i_tick) begin
            if (tick_cnt == BIT_TICK_LAST) begin
              tick_cnt <= '0;
              state    <= DATA;
              o_data   <= shreg[0];
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (tick_cnt == BIT_TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= shreg_shifted;
              if (bit_cnt == BIT_CNT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                state   <= PARITY;
                o_data  <= parity_bit;
`else
                state   <= STOP;
                o_data  <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                o_data  <= shreg_shifted[0];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (i_tick) begin
            if (tick_cnt == BIT_TICK_LAST) begin
              tick_cnt <= '0;
              state    <= STOP;
              o_data   <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (i_tick) begin
            if (tick_cnt == STOP_TICK_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              o_txdone <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_data <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx; the expected line level for
// each tick comes from a frame model built from data bits and tick counts.
module tb_uart_tx;

  localparam int NB         = 8;
  localparam int STOP_TICKS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_TICKS = (1 + NB) * 16 + 16 + STOP_TICKS;
`else
  localparam int FRAME_TICKS = (1 + NB) * 16 + STOP_TICKS;
`endif
  localparam int SLOW_DIV = 163;
  localparam int FAST_DIV = 4;
  localparam int NO_EVENT = -1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_tick;
  logic          i_start_tx;
  logic [NB-1:0] i_data;
  logic          o_txdone;
  logic          o_data;
  logic          slow_tick, fast_tick;
  int            tick_sel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  baudrate_generator u_slow_gen (.clk(clk), .i_rst_n(rst_n), .o_tick(slow_tick));
  baudrate_generator #(.BAUD_RATE(1_000_000), .CLK_FREQ(64_000_000), .OVERSAMPLING(16))
    u_fast_gen (.clk(clk), .i_rst_n(rst_n), .o_tick(fast_tick));

  assign i_tick = (tick_sel == 1) ? slow_tick : (tick_sel == 2) ? fast_tick : 1'b0;

  uart_tx #(.NB_DATA(NB), .NB_STOP(STOP_TICKS)) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_tick     (i_tick),
    .i_start_tx (i_start_tx),
    .i_data     (i_data),
    .o_txdone   (o_txdone),
    .o_data     (o_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Line level during tick n of a frame carrying d.
  function automatic logic exp_level(input logic [NB-1:0] d, input int n);
    int b;
    b = n / 16;
    if (b == 0) return 1'b0;
    if (b <= NB) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == NB + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Sends one frame and checks every tick. poke_tick pulses start with other
  // data mid-frame; abort_tick asserts reset mid-frame. Returns at the
  // negedge where o_txdone is seen (hold=1) or one clock after it.
  task automatic run_frame(input logic [NB-1:0] data, input bit hold, input int poke_tick,
                           input int abort_tick, input int limit, output int cycles);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    cycles = 0;
    i_data = data;
    i_start_tx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_data = NB'($urandom);
    check("start_level", o_data, 1'b0);
    check("start_txdone", o_txdone, 1'b0);
    while (!done && cycles < limit) begin
      if (!hold) i_start_tx = 1'b0;
      if (i_tick) begin
        check("line", o_data, exp_level(data, n));
        check("txdone_mid", o_txdone, 1'b0);
        if (n == poke_tick) begin
          i_start_tx = 1'b1;
          i_data = 8'h3C;
        end
        if (n == abort_tick) begin
          rst_n = 1'b0;
          i_start_tx = 1'b0;
          #1;
          check("abort_line", o_data, 1'b1);
          check("abort_txdone", o_txdone, 1'b0);
          repeat (4) begin
            @(negedge clk);
            check("abort_hold_txdone", o_txdone, 1'b0);
          end
          rst_n = 1'b1;
          return;
        end
        n++;
        if (n == FRAME_TICKS) begin
          @(negedge clk);
          cycles++;
          check("txdone_end", o_txdone, 1'b1);
          check("idle_after_stop", o_data, 1'b1);
          done = 1'b1;
        end
      end
      if (!done) begin
        @(negedge clk);
        cycles++;
      end
    end
    if (!done) begin
      check("frame_timeout", 32'(cycles), 32'(limit + 1));
      return;
    end
    if (!hold) begin
      i_start_tx = 1'b0;
      @(negedge clk);
      check("txdone_single", o_txdone, 1'b0);
      check("idle_line", o_data, 1'b1);
    end
  endtask

  task automatic measure_period(input string tag, input int expected);
    int c;
    c = 0;
    while (!i_tick && c < 1000) begin @(negedge clk); c++; end
    @(negedge clk);
    c = 1;
    while (!i_tick && c < 1000) begin @(negedge clk); c++; end
    check(tag, 32'(c), 32'(expected));
  endtask

  initial begin
    int cyc;
    int fast_limit;
    fast_limit = (FRAME_TICKS + 2) * FAST_DIV + 50;
    rst_n = 1'b0;
    i_start_tx = 1'b0;
    i_data = '0;
    tick_sel = 1;
    #50;
    check("reset_line", o_data, 1'b1);
    check("reset_txdone", o_txdone, 1'b0);
    #50;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with ticks running and no start request.
    for (int i = 0; i < 10; i++) begin
      repeat (40) @(negedge clk);
      check("idle_line", o_data, 1'b1);
      check("idle_txdone", o_txdone, 1'b0);
    end

    measure_period("slow_tick_period", SLOW_DIV);
    run_frame(8'hA5, 1'b0, NO_EVENT, NO_EVENT, (FRAME_TICKS + 2) * SLOW_DIV + 50, cyc);
    check("slow_frame_len", 32'((cyc > (FRAME_TICKS - 1) * SLOW_DIV) && (cyc <= FRAME_TICKS * SLOW_DIV + 1)), 32'd1);

    tick_sel = 2;
    measure_period("fast_tick_period", FAST_DIV);
    run_frame(8'hA5, 1'b0, 40, NO_EVENT, fast_limit, cyc);
    run_frame(8'h07, 1'b0, NO_EVENT, NO_EVENT, fast_limit, cyc);

    // Reset during DATA, fresh start needed, then a clean frame.
    run_frame(NB'($urandom), 1'b0, NO_EVENT, 16 * 3 + 5, fast_limit, cyc);
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge clk);
      check("post_abort_idle", o_data, 1'b1);
      check("post_abort_txdone", o_txdone, 1'b0);
    end
    run_frame(8'h5A, 1'b0, NO_EVENT, NO_EVENT, fast_limit, cyc);

    // Back-to-back frames with start held high.
    run_frame(NB'($urandom), 1'b1, NO_EVENT, NO_EVENT, fast_limit, cyc);
    run_frame(NB'($urandom), 1'b1, NO_EVENT, NO_EVENT, fast_limit, cyc);
    run_frame(NB'($urandom), 1'b0, NO_EVENT, NO_EVENT, fast_limit, cyc);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_frame(NB'($urandom), 1'b0,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FRAME_TICKS - 2)) : NO_EVENT,
                NO_EVENT, fast_limit, cyc);
    end

    // No ticks: the frame must stay in its start bit.
    tick_sel = 0;
    i_data = 8'hFF;
    i_start_tx = 1'b1;
    @(negedge clk);
    i_start_tx = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (30) @(negedge clk);
      check("stall_line", o_data, 1'b0);
      check("stall_txdone", o_txdone, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check("stall_reset_line", o_data, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick_sel = 2;
    run_frame(NB'($urandom), 1'b0, NO_EVENT, NO_EVENT, fast_limit, cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
